sync_reset_seq: RTL and testbench



---
 rtl/sync_reset_seq.sv | 171 +++++++++++++++++
 tb/tb_sync_reset_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sync_reset_seq.sv
// Reset sequencer: synchronises an active-high reset request, filters short
// low pulses with a hold window, then releases NCH reset channels in order,
// a fixed stagger apart, and flags completion once all are released.
module sync_reset_seq #(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned HOLD    = 8,
    parameter int unsigned STAGGER = 4,
    parameter int unsigned NCH     = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_RST,
    output logic [NCH-1:0] OUT_RST,
    output logic           RST_DONE
);

    localparam int unsigned MaxCnt = (HOLD > STAGGER) ? HOLD : STAGGER;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = $clog2(NCH) + 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
    localparam logic [CntW-1:0] StagLast = CntW'(STAGGER - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NCH - 1);

    typedef enum logic [1:0] {StAssert, StHold, StRelease, StDone} state_e;

    logic [STAGES-1:0] sync_q;
    logic              req_s;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NCH-1:0]    out_rst_q, out_rst_d;
    logic              rst_done_q, rst_done_d;

    // Synchroniser chain; resets high so the request reads as asserted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], IN_RST};
        end
    end

    assign req_s = sync_q[STAGES-1];

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StAssert;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_rst_q  <= '1;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            out_rst_q  <= out_rst_d;
            rst_done_q <= rst_done_d;
        end
    end

    // Next-state and counter update; a reassertion always wins over a terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            StAssert: begin
                if (!req_s) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StHold: begin
                if (req_s) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = (NCH == 1) ? StDone : StRelease;
                    cnt_d   = '0;
                    idx_d   = IdxW'(1);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                if (req_s) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == StagLast) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (req_s) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Next output values; channels only ever clear one bit at a time, lowest first.
    always_comb begin
        out_rst_d  = out_rst_q;
        rst_done_d = rst_done_q;
        unique case (state_q)
            StAssert: begin
                out_rst_d  = '1;
                rst_done_d = 1'b0;
            end
            StHold: begin
                out_rst_d  = '1;
                rst_done_d = 1'b0;
                if (!req_s && (cnt_q == HoldLast)) begin
                    out_rst_d[0] = 1'b0;
                    rst_done_d   = (NCH == 1);
                end
            end
            StRelease: begin
                if (req_s) begin
                    out_rst_d  = '1;
                    rst_done_d = 1'b0;
                end else if (cnt_q == StagLast) begin
                    for (int k = 0; k < int'(NCH); k++) begin
                        if (IdxW'(k) == idx_q) begin
                            out_rst_d[k] = 1'b0;
                        end
                    end
                    rst_done_d = (idx_q == IdxLast);
                end
            end
            StDone: begin
                if (req_s) begin
                    out_rst_d  = '1;
                    rst_done_d = 1'b0;
                end else begin
                    out_rst_d  = '0;
                    rst_done_d = 1'b1;
                end
            end
            default: begin
                out_rst_d  = '1;
                rst_done_d = 1'b0;
            end
        endcase
    end

    assign OUT_RST  = out_rst_q;
    assign RST_DONE = rst_done_q;

endmodule

// File: tb/tb_sync_reset_seq.sv
// Directed bench for sync_reset_seq: default configuration plus a
// single-channel instance (STAGES=3, HOLD=1, NCH=1).
module tb_sync_reset_seq;

    logic       CLK = 1'b0;
    logic       rst, in_rst;
    logic [3:0] out_rst;
    logic       rst_done;

    logic       rst1, in_rst1;
    logic       out_rst1;
    logic       rst_done1;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];
    logic [1:0] exp1_q[$];
    string      tag1_q[$];

    always #5 CLK = ~CLK;

    sync_reset_seq u_dut (
        .CLK     (CLK),
        .RST     (rst),
        .IN_RST  (in_rst),
        .OUT_RST (out_rst),
        .RST_DONE(rst_done)
    );

    sync_reset_seq #(
        .STAGES (3),
        .HOLD   (1),
        .STAGGER(4),
        .NCH    (1)
    ) u_dut1 (
        .CLK     (CLK),
        .RST     (rst1),
        .IN_RST  (in_rst1),
        .OUT_RST (out_rst1),
        .RST_DONE(rst_done1)
    );

    // Nominal schedule for the default configuration: n edges after the
    // first low sample, channel k drops at n = 10 + 4k, done with channel 3.
    function automatic logic [4:0] sched(input int n);
        int         lows;
        logic [3:0] o;
        lows = (n < 10) ? 0 : ((n - 10) / 4 + 1);
        if (lows > 4) lows = 4;
        o = 4'b1111 << lows;
        return {o, (lows == 4)};
    endfunction

    task automatic tick(input logic r, input logic ir, input logic [4:0] e, input string t);
        logic [4:0] ev;
        string      tv;
        rst    = r;
        in_rst = ir;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge CLK);
        #1;
        ev = exp_q.pop_front();
        tv = tag_q.pop_front();
        total++;
        assert ({out_rst, rst_done} === ev) else begin
            bad++;
            $error("FAIL %s: observed out/done=%b expected=%b", tv, {out_rst, rst_done}, ev);
        end
    endtask

    task automatic tick1(input logic r, input logic ir, input logic [1:0] e, input string t);
        logic [1:0] ev;
        string      tv;
        rst1    = r;
        in_rst1 = ir;
        exp1_q.push_back(e);
        tag1_q.push_back(t);
        @(posedge CLK);
        #1;
        ev = exp1_q.pop_front();
        tv = tag1_q.pop_front();
        total++;
        assert ({out_rst1, rst_done1} === ev) else begin
            bad++;
            $error("FAIL %s: observed out/done=%b expected=%b", tv, {out_rst1, rst_done1}, ev);
        end
    endtask

    initial begin
        rst     = 1'b1;
        in_rst  = 1'b1;
        rst1    = 1'b1;
        in_rst1 = 1'b1;

        // Master reset, request held high.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 5'b11110, $sformatf("reset %0d", i));
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 5'b11110, $sformatf("assert %0d", i));

        // Glitch: 5 low cycles is shorter than the hold window.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 5'b11110, $sformatf("glitch lo %0d", i));
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 5'b11110, $sformatf("glitch hi %0d", i));

        // Nominal release after RST with IN_RST low.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 5'b11110, $sformatf("nom rst %0d", i));
        for (int n = 0; n <= 24; n++) tick(1'b0, 1'b0, sched(n), $sformatf("nominal n=%0d", n));

        // One-cycle reassert pulse from DONE; new low edge is the edge after the pulse.
        tick(1'b0, 1'b1, 5'b00001, "done pulse");
        for (int m = 0; m <= 24; m++)
            tick(1'b0, 1'b0, (m == 0) ? 5'b00001 : sched(m), $sformatf("after pulse m=%0d", m));

        // Mid-sequence reassert sampled at E15.
        tick(1'b0, 1'b1, 5'b00001, "mid pre 0");
        tick(1'b0, 1'b1, 5'b00001, "mid pre 1");
        tick(1'b0, 1'b1, 5'b11110, "mid pre 2");
        for (int n = 0; n <= 14; n++) tick(1'b0, 1'b0, sched(n), $sformatf("mid n=%0d", n));
        tick(1'b0, 1'b1, 5'b11000, "mid E15");
        tick(1'b0, 1'b1, 5'b11000, "mid E16");
        tick(1'b0, 1'b1, 5'b11110, "mid E17");
        for (int n = 0; n <= 19; n++) tick(1'b0, 1'b0, sched(n), $sformatf("restart n=%0d", n));

        // Master reset while OUT_RST=1000, then nominal timing again.
        tick(1'b1, 1'b0, 5'b11110, "mrst");
        for (int n = 0; n <= 24; n++) tick(1'b0, 1'b0, sched(n), $sformatf("post mrst n=%0d", n));

        // Single-channel instance: release and done together after E4.
        for (int i = 0; i < 2; i++) tick1(1'b1, 1'b0, 2'b10, $sformatf("nch1 rst %0d", i));
        for (int n = 0; n <= 7; n++)
            tick1(1'b0, 1'b0, (n < 4) ? 2'b10 : 2'b01, $sformatf("nch1 n=%0d", n));
        tick1(1'b0, 1'b1, 2'b01, "nch1 pulse");
        for (int m = 0; m <= 6; m++)
            tick1(1'b0, 1'b0, (m < 2) ? 2'b01 : ((m < 4) ? 2'b10 : 2'b01),
                  $sformatf("nch1 after pulse m=%0d", m));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
